// File: rtl/m31_mul_vec.sv
// Multi-lane M31 (P = 2^31-1) multiplier: MUL, SQR or MAC per beat, one shared
// valid/ready handshake, whole-pipeline stall when the output is held.
module m31_mul_vec #(
  parameter int LANES      = 4,
  parameter int MUL_STAGES = 2,
  parameter int TAG_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [1:0]            op_i,
  input  logic [31*LANES-1:0]   a_i,
  input  logic [31*LANES-1:0]   b_i,
  input  logic [31*LANES-1:0]   c_i,
  input  logic [TAG_W-1:0]      tag_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [31*LANES-1:0]   res_o,
  output logic [TAG_W-1:0]      tag_o,
  output logic                  busy_o
);

  // stages after S0: M1..M{MUL_STAGES}, R1, R2, AO
  localparam int ND = MUL_STAGES + 3;
  localparam logic [30:0] P = 31'h7FFF_FFFF;
  localparam logic [1:0] OP_SQR = 2'b01;
  localparam logic [1:0] OP_MAC = 2'b10;

  logic en;

  logic [LANES-1:0][30:0] s0_a_q, s0_a_d, s0_b_q, s0_b_d, s0_c_q, s0_c_d;
  logic [TAG_W-1:0]       s0_tag_q, s0_tag_d;
  logic                   s0_vld_q, s0_vld_d;

  logic [MUL_STAGES-1:0][LANES-1:0][61:0] mul_q, mul_d;
  logic [LANES-1:0][31:0] r1_q, r1_d;
  logic [LANES-1:0][30:0] r2_q, r2_d;
  logic [LANES-1:0][30:0] res_q, res_d;

  logic [ND-2:0][LANES-1:0][30:0] pc_q, pc_d;
  logic [ND-1:0][TAG_W-1:0]       ptag_q, ptag_d;
  logic [ND-1:0]                  pvld_q, pvld_d;

  // Inputs never exceed 2^32-2 here, so a single end-around carry plus the
  // P -> 0 remap yields a canonical residue.
  function automatic logic [30:0] fold(input logic [31:0] s);
    logic [30:0] r;
    r = s[30:0] + 31'(s[31]);
    return (r == P) ? 31'd0 : r;
  endfunction

  assign out_valid_o = pvld_q[ND-1];
  assign en          = !out_valid_o || out_ready_i;
  assign in_ready_o  = en;
  assign res_o       = res_q;
  assign tag_o       = ptag_q[ND-1];
  assign busy_o      = s0_vld_q || (|pvld_q);

  always_comb begin
    s0_a_d   = s0_a_q;
    s0_b_d   = s0_b_q;
    s0_c_d   = s0_c_q;
    s0_tag_d = s0_tag_q;
    s0_vld_d = s0_vld_q;
    mul_d    = mul_q;
    r1_d     = r1_q;
    r2_d     = r2_q;
    res_d    = res_q;
    pc_d     = pc_q;
    ptag_d   = ptag_q;
    pvld_d   = pvld_q;
    if (en) begin
      s0_vld_d  = in_valid_i;
      s0_tag_d  = tag_i;
      pvld_d[0] = s0_vld_q;
      ptag_d[0] = s0_tag_q;
      pc_d[0]   = s0_c_q;
      for (int j = 1; j < ND; j++) begin
        pvld_d[j] = pvld_q[j-1];
        ptag_d[j] = ptag_q[j-1];
      end
      for (int j = 1; j < ND-1; j++) begin
        pc_d[j] = pc_q[j-1];
      end
      for (int m = 1; m < MUL_STAGES; m++) begin
        mul_d[m] = mul_q[m-1];
      end
      for (int l = 0; l < LANES; l++) begin
        s0_a_d[l]   = a_i[31*l +: 31];
        s0_b_d[l]   = (op_i == OP_SQR) ? a_i[31*l +: 31] : b_i[31*l +: 31];
        s0_c_d[l]   = (op_i == OP_MAC) ? c_i[31*l +: 31] : 31'd0;
        mul_d[0][l] = 62'(s0_a_q[l]) * 62'(s0_b_q[l]);
        r1_d[l]     = {1'b0, mul_q[MUL_STAGES-1][l][61:31]}
                    + {1'b0, mul_q[MUL_STAGES-1][l][30:0]};
        r2_d[l]     = fold(r1_q[l]);
        res_d[l]    = fold({1'b0, r2_q[l]} + {1'b0, pc_q[ND-2][l]});
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s0_a_q   <= '0;
      s0_b_q   <= '0;
      s0_c_q   <= '0;
      s0_tag_q <= '0;
      s0_vld_q <= 1'b0;
      mul_q    <= '0;
      r1_q     <= '0;
      r2_q     <= '0;
      res_q    <= '0;
      pc_q     <= '0;
      ptag_q   <= '0;
      pvld_q   <= '0;
    end else begin
      s0_a_q   <= s0_a_d;
      s0_b_q   <= s0_b_d;
      s0_c_q   <= s0_c_d;
      s0_tag_q <= s0_tag_d;
      s0_vld_q <= s0_vld_d;
      mul_q    <= mul_d;
      r1_q     <= r1_d;
      r2_q     <= r2_d;
      res_q    <= res_d;
      pc_q     <= pc_d;
      ptag_q   <= ptag_d;
      pvld_q   <= pvld_d;
    end
  end

endmodule

// File: doc/m31_mul_vec.md
# m31_mul_vec

Multi-lane, flow-controlled M31 multiplier. It computes LANES independent products a·b, squares a·a, or multiply-accumulates a·b + c modulo P = 2^31−1 each beat. All lanes share one valid/ready handshake, and the pipeline depth is configurable. It is the datapath workhorse for the Poseidon2 round units: the S-box, MDS and round-constant paths feed it vectors and apply backpressure through out_ready_i.

## Interface
- LANES, 4, number of parallel M31 lanes (1..16)
- MUL_STAGES, 2, register stages inside the 31×31 product (1..3)
- TAG_W, 8, width of the pass-through sideband tag (≥1)
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- in_valid_i  in  1  input beat valid
- in_ready_o  out  1  block can accept a beat this cycle
- op_i  in  2  mode: 00 MUL, 01 SQR, 10 MAC, 11 reserved (treated as MUL)
- a_i  in  31·LANES  operand A, lane n at [31n+30:31n]
- b_i  in  31·LANES  operand B (ignored in SQR)
- c_i  in  31·LANES  addend (used only in MAC, otherwise forced to 0)
- tag_i  in  TAG_W  sideband, returned unchanged with the result
- out_valid_o  out  1  result beat valid
- out_ready_i  in  1  consumer accepts the result
- res_o  out  31·LANES  canonical results in [0, P−1]
- tag_o  out  TAG_W  tag of the beat on res_o
- busy_o  out  1  any pipeline stage holds a valid beat

## Operation
- Stages: S0 input register (a, b′, c′, tag, valid), where b′ = a in SQR and c′ = 0 unless MAC.
- M1..M{MUL_STAGES}: 62-bit product.
- R1: {1'b0, p[61:31]} + {1'b0, p[30:0]}, 32 bits.
- R2: s[30:0] + s[31]; the value P maps to 0.
- AO: output register. Computes t = r + c′ (32 bits), folds it as t[30:0] + t[31], maps P to 0, and drives res_o.
- Each stage carries one valid bit. Tag and valid travel with the data.
- Global advance enable en = !out_valid_o || out_ready_i. When en = 0, every stage register, including S0, holds.
- in_ready_o = en, combinational. A beat is accepted on an edge where in_valid_i && in_ready_o.
- Bubbles are not compressed. A stage with valid = 0 still shifts whenever en = 1.
- Non-canonical input value P (0x7FFFFFFF) on a, b or c is legal and treated as 0. Outputs are always canonical.
- Lanes are fully independent. No cross-lane carry.
- busy_o = OR of all stage valid bits, including the output register.

## Timing
- Reset (rst_n low at an edge): all valid bits clear, all data and tag registers clear.
  - out_valid_o = 0, res_o = 0, tag_o = 0, busy_o = 0.
  - in_ready_o = 1 from the first cycle after reset.
- Reset mid-operation discards all in-flight beats. None are emitted afterward.
- Latency: a beat accepted at edge k with en held high has out_valid_o = 1 after edge k + MUL_STAGES + 3 (5 edges for the default).
- Throughput: one beat per cycle while out_ready_i = 1.
- Stall: out_valid_o && !out_ready_i freezes the whole pipeline. res_o and tag_o stay stable until the handshake completes.
- On the handshake edge, the next stage's contents (valid or bubble) move into the output register in the same cycle. This gives zero dead cycles.
- Simultaneous accept and emit on one edge is legal and required for full rate.
- Ordering is strict FIFO. No beat is dropped or duplicated under any out_ready_i pattern.

## Test plan
- MUL, LANES=4, lanes {2·3, 0·7, 1·(P−1), 65536·65536} → {6, 0, P−1, 2} exactly 5 edges after accept, tag echoed.
- SQR and MUL edge values: a=P−1 SQR → 1; a=P, b=12345 MUL → 0; a=0x40000000, b=2 → 1; b_i garbage in SQR → ignored.
- MAC: a=P−1, b=1, c=1 → 0; a=P−1, b=P−1, c=P−1 → 0; a=3, b=4, c=P → 12; c_i nonzero in MUL mode → ignored.
- Backpressure: stream 20 back-to-back beats with out_ready_i low for cycles 3–5 and 9.
  - Required: in_ready_o low exactly those cycles, all 20 results in order, correct values, res_o stable while stalled.
- Reset mid-stream: 4 beats in flight, rst_n low for 1 cycle.
  - Required: out_valid_o = 0 and busy_o = 0 next cycle, no stale beat emitted, a new beat afterward has correct latency.
- Randomized regression for MUL_STAGES ∈ {1,2,3}, LANES ∈ {1,4,16}: random ops, operands including 0, 1, P−1 and P, random valid and ready.
  - Scoreboard against a mod-P reference model. Latency measured equals MUL_STAGES + 3 edges under no stall.
